// File: rtl/core_bus_mux.sv
// core_bus_mux: single-master to N-slave request/ack interconnect. Decodes the
// top address bits into a slave index, holds the slave strobe until ack or
// timeout, and returns a one-cycle ack with error flag and registered read data.
module core_bus_mux #(
   parameter int unsigned N_SLAVES    = 2,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned REGION_BITS = 4,
   parameter int unsigned TIMEOUT     = 15
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           m_rd_en_i,
   input  logic                           m_wr_en_i,
   input  logic [ADDR_WIDTH-1:0]          m_addr_i,
   input  logic [DATA_WIDTH-1:0]          m_data_i,
   output logic [DATA_WIDTH-1:0]          m_data_o,
   output logic                           m_ack_o,
   output logic                           m_err_o,
   output logic                           m_busy_o,
   output logic [N_SLAVES-1:0]            s_rd_en_o,
   output logic [N_SLAVES-1:0]            s_wr_en_o,
   output logic [ADDR_WIDTH-1:0]          s_addr_o,
   output logic [DATA_WIDTH-1:0]          s_data_o,
   input  logic [N_SLAVES*DATA_WIDTH-1:0] s_data_i,
   input  logic [N_SLAVES-1:0]            s_ack_i,
   output logic [7:0]                     err_count_o
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

   state_t                 r_state,     w_state_nxt;
   logic [ADDR_WIDTH-1:0]  r_addr,      w_addr_nxt;
   logic [DATA_WIDTH-1:0]  r_wdata,     w_wdata_nxt;
   logic                   r_is_wr,     w_is_wr_nxt;
   logic [REGION_BITS-1:0] r_idx,       w_idx_nxt;
   logic [7:0]             r_cnt,       w_cnt_nxt;
   logic                   r_err,       w_err_nxt;
   logic [DATA_WIDTH-1:0]  r_rdata,     w_rdata_nxt;
   logic [7:0]             r_err_count, w_err_count_nxt;

   logic [REGION_BITS-1:0] w_req_idx;
   logic                   w_req;
   logic                   w_req_bad;
   logic [N_SLAVES-1:0]    w_sel;
   logic                   w_sel_ack;
   logic [DATA_WIDTH-1:0]  w_sel_rdata;
   logic                   w_timeout;
   logic [7:0]             w_err_count_inc;

   assign w_req_idx = m_addr_i[ADDR_WIDTH-1 -: REGION_BITS];
   assign w_req     = m_rd_en_i | m_wr_en_i;
   // Unmapped region or both operations requested at once: fail without touching a slave.
   assign w_req_bad = (32'(w_req_idx) >= N_SLAVES) | (m_rd_en_i & m_wr_en_i);

   // Counter holds cycles already spent in ACCESS; the current cycle is the last allowed.
   assign w_timeout       = (r_cnt == 8'(TIMEOUT - 1));
   assign w_err_count_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

   // One-hot select, ack and read-data mux for the latched slave index.
   always_comb begin
      w_sel       = '0;
      w_sel_rdata = '0;
      for (int unsigned i = 0; i < N_SLAVES; i++) begin
         if (32'(r_idx) == i) begin
            w_sel[i]    = 1'b1;
            w_sel_rdata = s_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      w_sel_ack = |(s_ack_i & w_sel);
   end

   // Next-state and datapath update for the transaction FSM.
   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_is_wr_nxt     = r_is_wr;
      w_idx_nxt       = r_idx;
      w_cnt_nxt       = r_cnt;
      w_err_nxt       = r_err;
      w_rdata_nxt     = r_rdata;
      w_err_count_nxt = r_err_count;
      unique case (r_state)
         StIdle: begin
            if (w_req) begin
               w_addr_nxt  = m_addr_i;
               w_wdata_nxt = m_data_i;
               // A read request takes precedence when naming the operation.
               w_is_wr_nxt = m_wr_en_i & ~m_rd_en_i;
               w_idx_nxt   = w_req_idx;
               w_cnt_nxt   = 8'd0;
               if (w_req_bad) begin
                  w_state_nxt     = StResp;
                  w_err_nxt       = 1'b1;
                  w_err_count_nxt = w_err_count_inc;
                  if (m_rd_en_i) w_rdata_nxt = '0;
               end else begin
                  w_state_nxt = StAccess;
                  w_err_nxt   = 1'b0;
               end
            end
         end
         StAccess: begin
            // Ack is checked first so an ack on the last allowed cycle still succeeds.
            if (w_sel_ack) begin
               w_state_nxt = StResp;
               w_err_nxt   = 1'b0;
               if (!r_is_wr) w_rdata_nxt = w_sel_rdata;
            end else if (w_timeout) begin
               w_state_nxt     = StResp;
               w_err_nxt       = 1'b1;
               w_err_count_nxt = w_err_count_inc;
               if (!r_is_wr) w_rdata_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         StResp: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_is_wr     <= 1'b0;
         r_idx       <= '0;
         r_cnt       <= 8'd0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_err_count <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_is_wr     <= w_is_wr_nxt;
         r_idx       <= w_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_err       <= w_err_nxt;
         r_rdata     <= w_rdata_nxt;
         r_err_count <= w_err_count_nxt;
      end
   end

   // Slave strobes: only the selected slave, only while in ACCESS.
   always_comb begin
      s_rd_en_o = '0;
      s_wr_en_o = '0;
      if (r_state == StAccess) begin
         if (r_is_wr) s_wr_en_o = w_sel;
         else         s_rd_en_o = w_sel;
      end
   end

   assign m_ack_o     = (r_state == StResp);
   assign m_err_o     = m_ack_o & r_err;
   assign m_busy_o    = (r_state != StIdle);
   assign m_data_o    = r_rdata;
   assign s_addr_o    = r_addr;
   assign s_data_o    = r_wdata;
   assign err_count_o = r_err_count;

endmodule

// File: doc/core_bus_mux.md
# core_bus_mux

Single-master, multi-slave bus interconnect between the core's memory port and up to N_SLAVES memory-like targets (boot ROM, data RAM, peripherals). It decodes the upper address bits into a slave index and runs each access as a request/ack transaction with a timeout. Completion is returned to the core as a one-cycle ack with registered read data, and unmapped or timed-out accesses are flagged as errors. It replaces the direct core-to-memory connection in the top level and adds wait-state tolerance and error reporting.

## Interface
- N_SLAVES, 2: number of slave ports, 1..16
- ADDR_WIDTH, 32: address width
- DATA_WIDTH, 32: data width
- REGION_BITS, 4: number of top address bits used as the slave index
- TIMEOUT, 15: maximum cycles in ACCESS waiting for ack, 1..255
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- m_rd_en_i  in  1  core read request, level
- m_wr_en_i  in  1  core write request, level
- m_addr_i  in  ADDR_WIDTH  core address
- m_data_i  in  DATA_WIDTH  core write data
- m_data_o  out  DATA_WIDTH  read data, registered
- m_ack_o  out  1  one-cycle completion pulse
- m_err_o  out  1  qualifies m_ack_o; 1 = failed access
- m_busy_o  out  1  high whenever state is not IDLE
- s_rd_en_o  out  N_SLAVES  per-slave read strobe
- s_wr_en_o  out  N_SLAVES  per-slave write strobe
- s_addr_o  out  ADDR_WIDTH  latched address, shared
- s_data_o  out  DATA_WIDTH  latched write data, shared
- s_data_i  in  N_SLAVES*DATA_WIDTH  slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_ack_i  in  N_SLAVES  per-slave ack
- err_count_o  out  8  saturating count of errored transactions

## Operation
- States: IDLE, ACCESS, RESP.
- Slave index: idx = m_addr_i[ADDR_WIDTH-1 -: REGION_BITS].
- Transitions out of IDLE, on a cycle with m_rd_en_i or m_wr_en_i high:
  - Latch address, write data, operation and idx.
  - idx >= N_SLAVES -> RESP with error.
  - m_rd_en_i and m_wr_en_i both high -> RESP with error; no slave strobe.
  - Otherwise -> ACCESS, with the timeout counter cleared.
- ACCESS:
  - Assert s_rd_en_o[idx] or s_wr_en_o[idx] continuously. All other strobes stay 0.
  - s_addr_o and s_data_o hold the latched values.
  - s_ack_i[idx] high -> capture s_data_i slice idx (reads only), then go to RESP with no error.
  - Acks from non-selected slaves are ignored.
  - The counter increments each cycle. Reaching TIMEOUT without an ack -> RESP with error.
  - A slave ack arriving in the same cycle the counter hits TIMEOUT wins; the access completes without error.
- RESP:
  - m_ack_o = 1 for exactly one cycle; m_err_o is valid alongside it.
  - Strobes are 0.
  - Next state is IDLE.
- Core requests are sampled only in IDLE; requests while m_busy_o = 1 are ignored. The core holds its request until m_ack_o.
- A request still asserted in the IDLE cycle after RESP starts a new transaction.
- m_data_o:
  - Updated only by read completions.
  - An errored read loads 0.
  - Writes leave it unchanged.
- err_count_o increments on every RESP with m_err_o = 1 and saturates at 255.
- Reset, including mid-transaction, from any state:
  - State returns to IDLE.
  - All strobes, m_ack_o, m_err_o, m_busy_o, m_data_o, s_addr_o, s_data_o and err_count_o go to 0.
  - Any in-flight access is abandoned with no ack.

## Timing
- Request sampled in cycle 0.
- Strobe is visible from cycle 1.
- A slave acking in cycle 1 (zero wait) gives m_ack_o in cycle 2. Minimum latency is 2 cycles.
- A slave acking in cycle 1+w gives m_ack_o in cycle 2+w.
- Decode or simultaneous-request error: m_ack_o with m_err_o in cycle 1.
- Timeout: the strobe is held for TIMEOUT cycles (cycles 1..TIMEOUT), then m_ack_o with m_err_o in cycle TIMEOUT+1.
- m_data_o is valid from the m_ack_o cycle and holds until the next read completes.
- Back-to-back transactions: the next request is sampled at the earliest one cycle after RESP. Throughput is 1 access per 3 cycles with zero-wait slaves.

## Test plan
- Read with zero wait: slave 1 returns 0xDEADBEEF and acks immediately; core reads 0x1000_0004 at cycle 0. Required: s_rd_en_o = 2'b10 at cycle 1; m_ack_o = 1, m_err_o = 0, m_data_o = 0xDEADBEEF at cycle 2.
- Write with 3 wait states: core writes 0x12345678 to 0x0000_0010. Required: s_wr_en_o[0] high for cycles 1..4 with s_data_o = 0x12345678; ack at cycle 5; m_data_o unchanged.
- Unmapped address: core reads 0xF000_0000 with N_SLAVES = 2. Required: no strobe; m_ack_o = 1, m_err_o = 1, m_data_o = 0 at cycle 1; err_count_o = 1.
- Timeout: slave 0 never acks, TIMEOUT = 15. Required: strobe for cycles 1..15, then ack with error at cycle 16. In a separate run where the ack arrives exactly at cycle 15: ack at cycle 16 with m_err_o = 0.
- Reset mid-access: assert rst during ACCESS. Required: strobes and all outputs are 0 in the next cycle, no m_ack_o, and a fresh read after reset completes normally.
- Saturation and simultaneous requests: 260 erroring transactions, including both m_rd_en_i and m_wr_en_i high. Required: every one errors with no slave strobe, and err_count_o stops at 255.
